// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SCK divider, CS setup/hold and per-transfer SPI mode.
// Optional internal loopback (MOSI->sample path, CSbar held high) enabled by `define SPI_MASTER_PARAM_LOOPBACK_EN.
module spi_master_param #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] DATA_MOSI,
  input  logic              MISO,
`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
  input  logic              LOOPBACK,
`endif
  output logic              MOSI,
  output logic              SCK,
  output logic              CSbar,
  output logic              BUSY,
  output logic              FIN,
  output logic [DATA_W-1:0] DATA_MISO
);

  localparam int MAX_T = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                              : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                lb_q, lb_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                fin_q, fin_d;
  logic                lb_start;
  logic                sample_src;
  logic                leading;

`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
  assign lb_start = LOOPBACK;
`else
  assign lb_start = 1'b0;
`endif

  // Loopback samples the bit currently being presented on MOSI.
  assign sample_src = lb_q ? mosi_q : MISO;
  assign leading    = ~edge_q[0];

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lb_d    = lb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    fin_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        sck_d  = mode_q[1];
        mosi_d = 1'b0;
        if (START) begin
          state_d = SETUP;
          mode_d  = MODE;
          lb_d    = lb_start;
          sck_d   = MODE[1];
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          // CPHA=0 presents the MSB with CSbar; CPHA=1 waits for the first leading edge.
          if (!MODE[0]) begin
            mosi_d = DATA_MOSI[DATA_W-1];
            tx_d   = {DATA_MOSI[DATA_W-2:0], 1'b0};
          end else begin
            tx_d   = DATA_MOSI;
          end
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = XFER;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      XFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + 1'b1;
          if (leading ^ mode_q[0]) begin
            rx_d = {rx_q[DATA_W-2:0], sample_src};
          end else if (edge_q != EDGE_LAST) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (edge_q == EDGE_LAST) begin
            state_d = HOLD;
            edge_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        sck_d = mode_q[1];
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          fin_d   = 1'b1;
          dout_d  = rx_q;
          mosi_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      lb_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lb_q    <= lb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      fin_q   <= fin_d;
    end
  end

  assign MOSI      = mosi_q;
  assign SCK       = sck_q;
  assign CSbar     = (state_q == IDLE) || lb_q;
  assign BUSY      = (state_q != IDLE);
  assign FIN       = fin_q;
  assign DATA_MISO = dout_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: randomized words/modes against a bit-level reference
// slave and a latency/edge-count model; loopback scenario runs when SPI_MASTER_PARAM_LOOPBACK_EN is defined.
module tb_spi_master_param;

  localparam int DW  = 16;
  localparam int CD  = 2;
  localparam int CSS = 1;
  localparam int CSH = 1;
  localparam int LAT = 1 + CSS + 2 * CD * DW + CSH;

  logic          SYS_CLK = 1'b0;
  logic          RST, START, MISO, LOOPBACK;
  logic [1:0]    MODE;
  logic [DW-1:0] DATA_MOSI;
  logic          MOSI, SCK, CSbar, BUSY, FIN;
  logic [DW-1:0] DATA_MISO;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_word, exp_sword, last_miso;
  logic [1:0]    exp_mode;
  logic          exp_lb;

  always #5 SYS_CLK = ~SYS_CLK;

  spi_master_param #(
    .DATA_W(DW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)
  ) dut (
    .SYS_CLK  (SYS_CLK),
    .RST      (RST),
    .START    (START),
    .MODE     (MODE),
    .DATA_MOSI(DATA_MOSI),
    .MISO     (MISO),
`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
    .LOOPBACK (LOOPBACK),
`endif
    .MOSI     (MOSI),
    .SCK      (SCK),
    .CSbar    (CSbar),
    .BUSY     (BUSY),
    .FIN      (FIN),
    .DATA_MISO(DATA_MISO)
  );

  // Called at a negedge; the next posedge accepts the request.
  task automatic launch(input logic [DW-1:0] w, input logic [DW-1:0] sw,
                        input logic [1:0] m, input logic lb);
    exp_word  = w;
    exp_sword = sw;
    exp_mode  = m;
    exp_lb    = lb;
    DATA_MOSI = w;
    MODE      = m;
    LOOPBACK  = lb;
    MISO      = m[0] ? 1'b0 : sw[DW-1];
    START     = 1'b1;
  endtask

  // Follows one transfer cycle by cycle, acting as the slave, until FIN or budget expiry.
  task automatic track(input string name, input int glitch_at, input int post_wait);
    int            cycles = 0;
    int            edges  = 0;
    int            extra  = 0;
    bit            got_fin = 0;
    bit            cs_bad = 0;
    bit            hold_bad = 0;
    bit            idle_bad = 0;
    logic          prev_sck;
    logic [DW-1:0] seen = '0;
    logic [DW-1:0] stx;
    logic [DW-1:0] want_rx;
    stx = exp_mode[0] ? exp_sword : (exp_sword << 1);
    while (!got_fin && cycles < LAT + 20) begin
      @(negedge SYS_CLK);
      cycles++;
      if (cycles == 1) begin
        START = 1'b0;
        total++;
        if (BUSY !== 1'b1 || SCK !== exp_mode[1])
          begin bad++; $display("FAIL %s first cycle: BUSY=%b SCK=%b want BUSY=1 SCK=%b", name, BUSY, SCK, exp_mode[1]); end
      end else if (SCK !== prev_sck) begin
        edges++;
        if (((edges % 2) == 1) ^ exp_mode[0]) begin
          seen = {seen[DW-2:0], MOSI};
        end else begin
          MISO = stx[DW-1];
          stx  = stx << 1;
        end
      end
      prev_sck = SCK;
      if (glitch_at > 0 && cycles == glitch_at) begin
        START = 1'b1; DATA_MOSI = '1; MODE = ~exp_mode; LOOPBACK = ~exp_lb;
      end else if (glitch_at > 0 && cycles == glitch_at + 1) begin
        START = 1'b0;
      end
      if (FIN === 1'b1) begin
        got_fin = 1;
      end else begin
        if (CSbar !== exp_lb) cs_bad = 1;
        if (DATA_MISO !== last_miso) hold_bad = 1;
      end
    end

    total++;
    if (!got_fin) begin
      bad++; $display("FAIL %s timeout: no FIN after %0d cycles, want FIN at cycle %0d", name, cycles, LAT);
    end else begin
      want_rx = exp_lb ? exp_word : exp_sword;
      total++;
      if (cycles != LAT) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, cycles, LAT); end
      total++;
      if (edges != 2 * DW) begin bad++; $display("FAIL %s sck edges: got %0d want %0d", name, edges, 2 * DW); end
      total++;
      if (seen !== exp_word) begin bad++; $display("FAIL %s mosi stream: got %h want %h", name, seen, exp_word); end
      total++;
      if (DATA_MISO !== want_rx) begin bad++; $display("FAIL %s data_miso: got %h want %h", name, DATA_MISO, want_rx); end
      total++;
      if (CSbar !== 1'b1 || BUSY !== 1'b0 || SCK !== exp_mode[1])
        begin bad++; $display("FAIL %s fin cycle: CSbar=%b BUSY=%b SCK=%b want 1 0 %b", name, CSbar, BUSY, SCK, exp_mode[1]); end
      last_miso = want_rx;
    end
    total++;
    if (cs_bad) begin bad++; $display("FAIL %s csbar during transfer: got toggling want constant %b", name, exp_lb); end
    total++;
    if (hold_bad) begin bad++; $display("FAIL %s data_miso hold: changed before FIN, want %h held", name, last_miso); end

    if (post_wait > 0) begin
      for (int i = 0; i < post_wait; i++) begin
        @(negedge SYS_CLK);
        if (FIN !== 1'b0) extra++;
        if (BUSY !== 1'b0 || CSbar !== 1'b1 || MOSI !== 1'b0 || SCK !== exp_mode[1]) idle_bad = 1;
      end
      total++;
      if (extra != 0) begin bad++; $display("FAIL %s extra fin: got %0d want 0", name, extra); end
      total++;
      if (idle_bad) begin bad++; $display("FAIL %s idle outputs: got non-idle want BUSY=0 CSbar=1 MOSI=0 SCK=%b", name, exp_mode[1]); end
    end
  endtask

  task automatic test_reset();
    @(negedge SYS_CLK);
    total++;
    if (CSbar !== 1'b1 || SCK !== 1'b0 || MOSI !== 1'b0 || BUSY !== 1'b0 || FIN !== 1'b0 || DATA_MISO !== '0)
      begin bad++; $display("FAIL reset: got CSbar=%b SCK=%b MOSI=%b BUSY=%b FIN=%b DATA_MISO=%h want 1 0 0 0 0 0",
                            CSbar, SCK, MOSI, BUSY, FIN, DATA_MISO); end
    RST = 1'b0;
    last_miso = '0;
    exp_mode  = 2'b00;
    @(negedge SYS_CLK);
    total++;
    if (BUSY !== 1'b0 || CSbar !== 1'b1)
      begin bad++; $display("FAIL reset release: got BUSY=%b CSbar=%b want 0 1", BUSY, CSbar); end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      launch(16'hA5C3, 16'h3C5A, 2'(m), 1'b0);
      track($sformatf("mode%0d", m), 0, 3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      launch(DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)), 1'b0);
      track($sformatf("random%0d", i), 0, 1);
    end
  endtask

  task automatic test_start_ignored();
    launch(16'h6E17, 16'h9B20, 2'b01, 1'b0);
    track("start_ignored", 10, LAT + 5);
  endtask

  task automatic test_back_to_back();
    launch(16'hC0DE, 16'h0F0F, 2'b10, 1'b0);
    track("b2b_first", 0, 0);
    launch(16'h1234, 16'h4321, 2'b10, 1'b0);
    track("b2b_second", 0, 2);
  endtask

  task automatic test_reset_mid();
    int rst_at = 1 + CSS + 2 * CD * (DW - 8) + 1;
    int extra  = 0;
    launch(16'h5A5A, 16'hC3C3, 2'b11, 1'b0);
    for (int c = 1; c <= rst_at; c++) begin
      @(negedge SYS_CLK);
      if (c == 1) START = 1'b0;
    end
    RST = 1'b1;
    @(negedge SYS_CLK);
    total++;
    if (CSbar !== 1'b1 || SCK !== 1'b0 || BUSY !== 1'b0 || DATA_MISO !== '0 || FIN !== 1'b0 || MOSI !== 1'b0)
      begin bad++; $display("FAIL reset_mid: got CSbar=%b SCK=%b BUSY=%b DATA_MISO=%h FIN=%b MOSI=%b want 1 0 0 0 0 0",
                            CSbar, SCK, BUSY, DATA_MISO, FIN, MOSI); end
    RST = 1'b0;
    last_miso = '0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge SYS_CLK);
      if (FIN !== 1'b0) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL reset_mid fin: got %0d pulses want 0", extra); end
    launch(16'hBEEF, 16'h1357, 2'b00, 1'b0);
    track("after_reset", 0, 2);
  endtask

`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
  task automatic test_loopback();
    launch(16'h8001, 16'h7FFE, 2'b00, 1'b1);
    track("loopback_m0", 0, 2);
    launch(16'h8001, 16'h7FFE, 2'b11, 1'b1);
    track("loopback_m3", 0, 2);
    launch(16'h2468, 16'hFFFF, 2'b00, 1'b0);
    track("loopback_off", 0, 2);
  endtask
`endif

  initial begin
    RST = 1'b1; START = 1'b0; MODE = 2'b00; DATA_MOSI = '0; MISO = 1'b0; LOOPBACK = 1'b0;
    exp_word = '0; exp_sword = '0; exp_mode = 2'b00; exp_lb = 1'b0; last_miso = '0;
    repeat (2) @(negedge SYS_CLK);
    test_reset();
    test_modes();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master, next generation of the fixed 16-bit SPI master device. Supports configurable word width, SCK divider, all four SPI modes (selected per transfer), and programmable CS setup/hold. Uses an explicit START/BUSY/FIN handshake. Sits between ADC/DAC control logic and external SPI converters on the 10BASE-T ADC board.

Parameters:
DATA_W, 16, bits per transfer (2..32)
CLK_DIV, 2, SCK half-period in SYS_CLK cycles (>=1)
CS_SETUP, 1, SYS_CLK cycles from CSbar fall to first SCK edge (>=1)
CS_HOLD, 1, SYS_CLK cycles from last SCK edge to CSbar rise (>=1)

Ports:
SYS_CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
START  in  1  transfer request; accepted only when BUSY=0
MODE  in  2  {CPOL,CPHA}; latched with DATA_MOSI on accepted START
DATA_MOSI  in  DATA_W  word to send, MSB first; latched on accepted START
MISO  in  1  serial data from slave
MOSI  out  1  serial data to slave
SCK  out  1  SPI clock
CSbar  out  1  active-low chip select
BUSY  out  1  high in every state except IDLE
FIN  out  1  one-cycle pulse at transfer completion
DATA_MISO  out  DATA_W  last received word; held until next FIN

Behaviour:
- Reset values: CSbar=1, SCK=0, MOSI=0, BUSY=0, FIN=0, DATA_MISO=0, latched MODE=0, state=IDLE. RST mid-transfer aborts in the next cycle to the same values. DATA_MISO is cleared and no FIN is issued.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: SCK=latched CPOL, CSbar=1, MOSI=0. START=1 latches MODE and DATA_MOSI, goes to SETUP.
- SETUP: CSbar=0 for CS_SETUP cycles.
  - CPHA=0: MOSI=bit DATA_W-1 from the first SETUP cycle.
  - CPHA=1: MOSI is updated on the first SCK edge.
- XFER: SCK toggles every CLK_DIV cycles, giving 2*DATA_W edges in total. Edges alternate leading/trailing starting with leading; the last edge is trailing, so SCK ends at CPOL.
  - CPHA=0: sample MISO on leading edges; shift MOSI to the next bit on trailing edges. No shift after the final edge.
  - CPHA=1: shift MOSI on leading edges (first leading edge presents bit DATA_W-1); sample MISO on trailing edges.
- Received bits shift in MSB first. After the DATA_W-th sample, the shift register holds the complete word.
- HOLD: CSbar=0, SCK=CPOL for CS_HOLD cycles. Then go to IDLE.
- On the first IDLE cycle after HOLD:
  - CSbar=1, FIN=1, BUSY=0.
  - DATA_MISO updates on that same clock edge.
  - START in that cycle is accepted (back-to-back transfers allowed).
- Latency: accepted START at cycle 0 gives FIN at cycle 1 + CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD.
- START while BUSY=1 is ignored. DATA_MOSI/MODE changes while BUSY do not affect the current transfer.
- Bit and divider counters are sized by $clog2. No counter wraps within a transfer.

Optional Feature:
- Macro: SPI_MASTER_PARAM_LOOPBACK_EN.
- Defined: adds input port LOOPBACK (1 bit), latched on accepted START. When latched high:
  - The internal MISO sample source is the block's own MOSI, so DATA_MISO equals the sent word.
  - The external MOSI pin is still driven; CSbar stays high for the whole transfer.
- Undefined: no LOOPBACK port; MISO is always the sample source.

Test Plan:
- Mode 0, DATA_W=16, CLK_DIV=2, CS_SETUP=CS_HOLD=1; send 0xA5C3 with slave model returning 0x3C5A -> MOSI stream 0xA5C3 MSB first; DATA_MISO=0x3C5A; FIN at cycle 67 after START; 32 SCK edges.
- Modes 1, 2 and 3 with the same words -> correct edge alignment per mode; SCK idles at CPOL (1 for modes 2 and 3); identical DATA_MISO=0x3C5A.
- START pulsed at cycle 10 of an active transfer with DATA_MOSI=0xFFFF -> ignored; first word completes unchanged; exactly one FIN.
- START held high on the FIN cycle with a new word 0x1234 -> second transfer begins next cycle; CSbar high for exactly 1 cycle between words.
- RST asserted mid-XFER (bit 7) -> next cycle CSbar=1, SCK=0, BUSY=0, DATA_MISO=0, no FIN; a subsequent transfer completes normally.
- With SPI_MASTER_PARAM_LOOPBACK_EN defined and LOOPBACK=1, send 0x8001 -> DATA_MISO=0x8001 and CSbar stays 1 throughout.
